fp_result_collector: RTL and testbench
======================================

// Module: fp_result_collector
// PURPOSE
// Credit-based issue gate and result buffer for a non-stallable FP unit pipeline (e.g. FP multiplier).
// The unit always reports ready and ignores acknowledge, so this block:
//   - admits an operation only when a buffer slot is reserved for its result;
//   - captures every result/tag/status the unit produces;
//   - presents results in order to the APU result interconnect with a valid/ack handshake.
// PARAMETERS
// FP_WIDTH    32  result width
// TAG_WIDTH   5   tag width (requester ID)
// STAT_WIDTH  8   status flag width
// DEPTH       4   result buffer entries, >=2; also the maximum number of reserved slots
// PORTS
// clk_i        in   1           clock
// rst_ni       in   1           asynchronous active-low reset
// Req_i        in   1           dispatcher requests issue of one operation
// Gnt_o        out  1           issue allowed this cycle
// En_o         out  1           enable to FP unit (= Req_i & Gnt_o)
// Valid_i      in   1           FP unit result valid
// Res_i        in   FP_WIDTH    FP unit result
// Tag_i        in   TAG_WIDTH   FP unit result tag
// Status_i     in   STAT_WIDTH  FP unit status flags
// Valid_o      out  1           buffered result available
// Res_o        out  FP_WIDTH    head result
// Tag_o        out  TAG_WIDTH   head tag
// Status_o     out  STAT_WIDTH  head status
// Ack_i        in   1           consumer accepts head (pop when Valid_o & Ack_i)
// Overflow_o   out  1           sticky error: Valid_i arrived while buffer full
// BEHAVIOUR
// Reset is asynchronous on rst_ni low. During and after reset:
//   - all outputs are 0 except Gnt_o, which is 1;
//   - the reservation counter and read/write pointers are 0; Overflow_o is cleared;
//   - in-flight upstream results present at reset release are not tracked (upstream resets together).
// Reservation counter Rsv_SP, width $clog2(DEPTH+1), counts issued-but-not-popped operations:
//   - Rsv +1 on issue (Req_i & Gnt_o); Rsv -1 on pop; unchanged when both occur in the same cycle.
//   - Gnt_o = (Rsv_SP < DEPTH). Gnt_o depends on registered state only, with no path from Ack_i.
//   - At Rsv_SP==DEPTH, Gnt_o stays 0 even if a pop occurs that cycle. It rises the next cycle.
// Buffer: circular FIFO of DEPTH entries {Res, Tag, Status}.
//   - Write pointer advances on Valid_i; read pointer advances on pop. Pointers wrap DEPTH-1 -> 0.
//   - Full/empty are tracked with an occupancy count, width $clog2(DEPTH+1).
//   - Registered output, no fall-through: a result written in cycle N is visible on Valid_o/Res_o at N+1 at the earliest.
//   - With simultaneous write and pop, occupancy is unchanged; a full buffer accepts a write in the same cycle as a pop.
//   - Valid_o = (occupancy != 0). Res_o/Tag_o/Status_o show the head entry; their value is don't-care when Valid_o=0.
//   - Result order is preserved: results are delivered in arrival order on Valid_i.
//   - Ack_i while Valid_o=0 has no effect.
// Overflow (occupancy==DEPTH, Valid_i=1, no pop): the write is dropped and Overflow_o is set.
//   - Overflow_o clears only on reset.
//   - Overflow is unreachable when the credit rule is obeyed; the bench checks it never fires in legal use.
// A Valid_i with no outstanding reservation (Rsv_SP==occupancy) is a protocol error.
//   - The data is still stored if space allows; covered by assertion.
// TESTING
// 1) Reset, Req_i=1 for 4 cycles, unit latency 2, Ack_i=1 -> Gnt_o=1 throughout.
//    Results appear in order 2 cycles after issue; Valid_o rises 1 cycle later.
// 2) DEPTH=4, Ack_i=0, Req_i held -> exactly 4 grants, then Gnt_o=0; all 4 results buffered.
//    A single Ack_i then pops the head and Gnt_o=1 the following cycle.
// 3) Buffer full plus a simultaneous Valid_i and pop (forced) -> occupancy stays 4, no Overflow_o.
//    Tags are delivered in order with correct pointer wrap.
// 4) Force Valid_i with buffer full and Ack_i=0 -> Overflow_o=1 and sticky.
//    The head entry is unchanged; the dropped value never appears.
// 5) Assert rst_ni low with 3 results buffered and 1 in flight -> Valid_o=0 and Gnt_o=1 immediately (async).
//    Rsv and occupancy read 0 after release.
// 6) Random Req_i/Ack_i for 10k cycles against a scoreboard -> no loss, no reorder, no overflow.
//    Rsv_SP <= DEPTH always holds.

Source files
------------

// File: rtl/fp_result_collector.sv
// -----------------------------------------------------------------------------
// fp_result_collector
//
// Issue gate and in-order result buffer for a non-stallable FP unit pipeline.
// The FP unit accepts an operation every cycle and cannot be back-pressured.
// This block therefore reserves a buffer slot before it grants an issue. It
// captures every result the unit returns and hands the results to the APU
// result interconnect in arrival order, using a valid/ack handshake.
//
// Ports
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   Req_i       dispatcher requests issue of one operation
//   Gnt_o       issue allowed this cycle (a slot is still unreserved)
//   En_o        enable to the FP unit (Req_i & Gnt_o)
//   Valid_i     FP unit result valid
//   Res_i       FP unit result
//   Tag_i       FP unit result tag (requester ID)
//   Status_i    FP unit status flags
//   Valid_o     a buffered result is available
//   Res_o       head result   (0 while Valid_o is low)
//   Tag_o       head tag      (0 while Valid_o is low)
//   Status_o    head status   (0 while Valid_o is low)
//   Ack_i       consumer accepts the head entry (pop on Valid_o & Ack_i)
//   Overflow_o  sticky: a result arrived while the buffer was full
//
// PROTO_CHECK enables the check that each incoming result has an outstanding
// reservation. A bench that injects results deliberately clears it.
// -----------------------------------------------------------------------------
module fp_result_collector #(
  parameter int unsigned FP_WIDTH    = 32,
  parameter int unsigned TAG_WIDTH   = 5,
  parameter int unsigned STAT_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter bit          PROTO_CHECK = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  Req_i,
  output logic                  Gnt_o,
  output logic                  En_o,
  input  logic                  Valid_i,
  input  logic [FP_WIDTH-1:0]   Res_i,
  input  logic [TAG_WIDTH-1:0]  Tag_i,
  input  logic [STAT_WIDTH-1:0] Status_i,
  output logic                  Valid_o,
  output logic [FP_WIDTH-1:0]   Res_o,
  output logic [TAG_WIDTH-1:0]  Tag_o,
  output logic [STAT_WIDTH-1:0] Status_o,
  input  logic                  Ack_i,
  output logic                  Overflow_o
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_C  = PW'(DEPTH - 1);

  typedef struct packed {
    logic [FP_WIDTH-1:0]   res;
    logic [TAG_WIDTH-1:0]  tag;
    logic [STAT_WIDTH-1:0] status;
  } entry_t;

  // Result storage holds data only, so it is not reset. Valid_o qualifies it.
  entry_t mem_q [DEPTH];

  logic [CW-1:0] rsv_q, rsv_d;       // issued but not yet popped
  logic [CW-1:0] occ_q, occ_d;       // entries currently buffered
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          ovf_q, ovf_d;

  logic   issue;
  logic   pop;
  logic   full;
  logic   wr_en;
  entry_t head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_C) ? '0 : p + 1'b1;
  endfunction

  // The grant comes from registered state only. A pop in the same cycle does
  // not reopen the gate, which keeps Ack_i out of the issue path.
  assign Gnt_o = (rsv_q < DEPTH_C);
  assign issue = Req_i & Gnt_o;
  assign En_o  = issue;

  assign Valid_o = (occ_q != '0);
  assign pop     = Valid_o & Ack_i;
  assign full    = (occ_q == DEPTH_C);

  // A full buffer can still take a write when the head leaves the same cycle.
  assign wr_en = Valid_i & (~full | pop);

  always_comb begin
    rsv_d    = rsv_q;
    occ_d    = occ_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;

    case ({issue, pop})
      2'b10:   rsv_d = rsv_q + 1'b1;
      // Injected results can be popped with no reservation left. Hold at zero.
      2'b01:   if (rsv_q != '0) rsv_d = rsv_q - 1'b1;
      default: rsv_d = rsv_q;
    endcase

    case ({wr_en, pop})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase

    if (wr_en) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (pop)   rd_ptr_d = ptr_inc(rd_ptr_q);

    if (Valid_i & full & ~pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rsv_q    <= '0;
      occ_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      rsv_q    <= rsv_d;
      occ_q    <= occ_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= '{res: Res_i, tag: Tag_i, status: Status_i};
  end

  // The head is read from registered storage, so a result written this cycle
  // appears on the outputs no earlier than the next cycle.
  assign head       = mem_q[rd_ptr_q];
  assign Res_o      = Valid_o ? head.res    : '0;
  assign Tag_o      = Valid_o ? head.tag    : '0;
  assign Status_o   = Valid_o ? head.status : '0;
  assign Overflow_o = ovf_q;

  a_rsv_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    rsv_q <= DEPTH_C)
    else $error("reservation count above buffer depth");

  a_occ_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    occ_q <= DEPTH_C)
    else $error("occupancy above buffer depth");

  // rsv_q - occ_q is the number of operations still in the FP unit. A result
  // that arrives when that difference is zero has no reservation.
  a_result_reserved: assert property (@(posedge clk_i)
    disable iff (!rst_ni || !PROTO_CHECK)
    Valid_i |-> (rsv_q != occ_q))
    else $error("result arrived without an outstanding reservation");

endmodule

// File: tb/tb_fp_result_collector.sv
module tb_fp_result_collector;

  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        Req_i, Gnt_o, En_o;
  logic        Valid_i;
  logic [31:0] Res_i;
  logic [4:0]  Tag_i;
  logic [7:0]  Status_i;
  logic        Valid_o;
  logic [31:0] Res_o;
  logic [4:0]  Tag_o;
  logic [7:0]  Status_o;
  logic        Ack_i;
  logic        Overflow_o;

  int tests = 0;
  int fails = 0;

  // FP unit model: latency 2, driven by the bench's own grant prediction
  logic       s1_v, s2_v;
  logic [7:0] s1_id, s2_id;
  int         next_id;

  // scoreboard
  logic [7:0] exp_q[$];
  int         m_rsv, m_occ;
  int         en_cnt;

  fp_result_collector #(
    .FP_WIDTH(32), .TAG_WIDTH(5), .STAT_WIDTH(8), .DEPTH(DEPTH), .PROTO_CHECK(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .Req_i(Req_i), .Gnt_o(Gnt_o), .En_o(En_o),
    .Valid_i(Valid_i), .Res_i(Res_i), .Tag_i(Tag_i), .Status_i(Status_i),
    .Valid_o(Valid_o), .Res_o(Res_o), .Tag_o(Tag_o), .Status_o(Status_o),
    .Ack_i(Ack_i), .Overflow_o(Overflow_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] res_of(input logic [7:0] id);
    return {16'hC0DE, 8'h00, id};
  endfunction

  function automatic logic [7:0] status_of(input logic [7:0] id);
    return id ^ 8'hA5;
  endfunction

  // One clock cycle: inputs are driven at posedge+1, the DUT enable is sampled
  // at negedge, and the models are updated at the following posedge+1.
  task automatic cycle(input logic req, input logic ack, input logic fv, input logic [7:0] fid);
    logic       m_en, m_pop, vin;
    logic [7:0] vid;
    Req_i    = req;
    Ack_i    = ack;
    vin      = fv ? 1'b1 : s2_v;
    vid      = fv ? fid : s2_id;
    Valid_i  = vin;
    Res_i    = res_of(vid);
    Tag_i    = vid[4:0];
    Status_i = status_of(vid);
    @(negedge clk_i);
    if (En_o === 1'b1) en_cnt++;
    @(posedge clk_i);
    #1;
    m_en  = req && (m_rsv < DEPTH);
    m_pop = ack && (m_occ != 0);
    if (m_pop) begin
      void'(exp_q.pop_front());
      m_occ--;
      if (m_rsv > 0) m_rsv--;
    end
    if (vin && m_occ < DEPTH) begin
      exp_q.push_back(vid);
      m_occ++;
    end
    if (m_en) m_rsv++;
    s2_v  = s1_v;
    s2_id = s1_id;
    s1_v  = m_en;
    if (m_en) begin
      s1_id = next_id[7:0];
      next_id++;
    end
  endtask

  task automatic clear_models();
    s1_v = 1'b0; s2_v = 1'b0; s1_id = '0; s2_id = '0;
    exp_q.delete();
    m_rsv = 0; m_occ = 0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0; Req_i = 1'b0; Ack_i = 1'b0; Valid_i = 1'b0;
    Res_i = '0; Tag_i = '0; Status_i = '0;
    clear_models();
    next_id = 0; en_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    tests++; if (Gnt_o !== 1'b1) begin fails++; $display("FAIL reset_gnt: got %b want 1", Gnt_o); end
    tests++; if (Valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", Valid_o); end
    tests++; if (En_o !== 1'b0) begin fails++; $display("FAIL reset_en: got %b want 0", En_o); end
    tests++; if (Overflow_o !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", Overflow_o); end
    tests++; if ({Res_o, Tag_o, Status_o} !== 45'h0) begin fails++; $display("FAIL reset_data: got %h/%h/%h want 0", Res_o, Tag_o, Status_o); end
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tests++; if (dut.rsv_q !== 3'd0) begin fails++; $display("FAIL reset_rsv: got %0d want 0", dut.rsv_q); end
    tests++; if (dut.occ_q !== 3'd0) begin fails++; $display("FAIL reset_occ: got %0d want 0", dut.occ_q); end
    tests++; if (Gnt_o !== 1'b1) begin fails++; $display("FAIL release_gnt: got %b want 1", Gnt_o); end
  endtask

  // Four issues with the consumer always ready: results reach Valid_o three
  // cycles after their issue cycle, in issue order.
  task automatic test_stream();
    int         base;
    logic       exp_v [7];
    int         exp_off [7];
    logic [7:0] id;
    base = next_id;
    exp_v   = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_off = '{0, 0, 0, 1, 2, 3, 0};
    for (int k = 0; k < 7; k++) begin
      cycle(k < 4, 1'b1, 1'b0, 8'h00);
      id = 8'(base + exp_off[k]);
      tests++; if (Gnt_o !== 1'b1) begin fails++; $display("FAIL stream_gnt[%0d]: got %b want 1", k, Gnt_o); end
      tests++; if (Valid_o !== exp_v[k]) begin fails++; $display("FAIL stream_valid[%0d]: got %b want %b", k, Valid_o, exp_v[k]); end
      if (exp_v[k]) begin
        tests++;
        if (Tag_o !== id[4:0] || Res_o !== res_of(id) || Status_o !== status_of(id)) begin
          fails++; $display("FAIL stream_head[%0d]: got %h/%h/%h want %h/%h/%h", k, Tag_o, Res_o, Status_o, id[4:0], res_of(id), status_of(id));
        end
      end
    end
    tests++; if (Overflow_o !== 1'b0) begin fails++; $display("FAIL stream_ovf: got %b want 0", Overflow_o); end
  endtask

  task automatic test_credit_full();
    int         base, c0;
    logic [7:0] id;
    base = next_id;
    c0 = en_cnt;
    repeat (8) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if (en_cnt - c0 != 4) begin fails++; $display("FAIL credit_grants: got %0d want 4", en_cnt - c0); end
    tests++; if (Gnt_o !== 1'b0) begin fails++; $display("FAIL credit_gnt_low: got %b want 0", Gnt_o); end
    tests++; if (En_o !== 1'b0) begin fails++; $display("FAIL credit_en_low: got %b want 0", En_o); end
    tests++; if (dut.occ_q !== 3'd4) begin fails++; $display("FAIL credit_occ: got %0d want 4", dut.occ_q); end
    id = 8'(base);
    tests++; if (Valid_o !== 1'b1 || Tag_o !== id[4:0]) begin fails++; $display("FAIL credit_head: got %b/%h want 1/%h", Valid_o, Tag_o, id[4:0]); end
    c0 = en_cnt;
    cycle(1'b1, 1'b1, 1'b0, 8'h00);
    tests++; if (en_cnt != c0) begin fails++; $display("FAIL credit_pop_cycle_grant: got %0d grants want 0", en_cnt - c0); end
    tests++; if (Gnt_o !== 1'b1) begin fails++; $display("FAIL credit_gnt_after_pop: got %b want 1", Gnt_o); end
    id = 8'(base + 1);
    tests++; if (Tag_o !== id[4:0]) begin fails++; $display("FAIL credit_head_after_pop: got %h want %h", Tag_o, id[4:0]); end
    tests++; if (dut.occ_q !== 3'd3) begin fails++; $display("FAIL credit_occ_after_pop: got %0d want 3", dut.occ_q); end
  endtask

  task automatic test_full_wrap();
    int         b;
    logic [7:0] ids [3];
    logic [7:0] id;
    b = next_id - 4;
    cycle(1'b1, 1'b0, 1'b0, 8'h00);
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (dut.occ_q !== 3'd4) begin fails++; $display("FAIL wrap_full_occ: got %0d want 4", dut.occ_q); end
    cycle(1'b0, 1'b1, 1'b1, 8'h77);
    tests++; if (dut.occ_q !== 3'd4) begin fails++; $display("FAIL wrap_occ_write_pop: got %0d want 4", dut.occ_q); end
    tests++; if (Overflow_o !== 1'b0) begin fails++; $display("FAIL wrap_ovf: got %b want 0", Overflow_o); end
    id = 8'(b + 2);
    tests++; if (Tag_o !== id[4:0]) begin fails++; $display("FAIL wrap_head: got %h want %h", Tag_o, id[4:0]); end
    ids = '{8'(b + 3), 8'(b + 4), 8'h77};
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      tests++;
      if (Valid_o !== 1'b1 || Tag_o !== ids[k][4:0] || Res_o !== res_of(ids[k])) begin
        fails++; $display("FAIL wrap_order[%0d]: got %b/%h/%h want 1/%h/%h", k, Valid_o, Tag_o, Res_o, ids[k][4:0], res_of(ids[k]));
      end
    end
    cycle(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (Valid_o !== 1'b0) begin fails++; $display("FAIL wrap_empty: got %b want 0", Valid_o); end
  endtask

  task automatic test_overflow();
    int         b;
    logic [7:0] id;
    b = next_id;
    repeat (6) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if (dut.occ_q !== 3'd4) begin fails++; $display("FAIL ovf_fill_occ: got %0d want 4", dut.occ_q); end
    cycle(1'b0, 1'b0, 1'b1, 8'h99);
    tests++; if (Overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_set: got %b want 1", Overflow_o); end
    id = 8'(b);
    tests++; if (Tag_o !== id[4:0] || Res_o !== res_of(id)) begin fails++; $display("FAIL ovf_head: got %h/%h want %h/%h", Tag_o, Res_o, id[4:0], res_of(id)); end
    tests++; if (dut.occ_q !== 3'd4) begin fails++; $display("FAIL ovf_occ: got %0d want 4", dut.occ_q); end
    repeat (3) cycle(1'b0, 1'b0, 1'b0, 8'h00);
    tests++; if (Overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", Overflow_o); end
    for (int k = 0; k < 4; k++) begin
      cycle(1'b0, 1'b1, 1'b0, 8'h00);
      id = 8'(b + k + 1);
      if (k < 3) begin
        tests++;
        if (Valid_o !== 1'b1 || Tag_o !== id[4:0] || Status_o !== status_of(id)) begin
          fails++; $display("FAIL ovf_drain[%0d]: got %b/%h/%h want 1/%h/%h", k, Valid_o, Tag_o, Status_o, id[4:0], status_of(id));
        end
      end else begin
        tests++; if (Valid_o !== 1'b0) begin fails++; $display("FAIL ovf_dropped_seen: got %b/%h want 0", Valid_o, Tag_o); end
      end
    end
    tests++; if (Overflow_o !== 1'b1) begin fails++; $display("FAIL ovf_sticky_after_drain: got %b want 1", Overflow_o); end
  endtask

  task automatic test_async_reset();
    repeat (5) cycle(1'b1, 1'b0, 1'b0, 8'h00);
    tests++; if (dut.occ_q !== 3'd3) begin fails++; $display("FAIL areset_pre_occ: got %0d want 3", dut.occ_q); end
    tests++; if (s2_v !== 1'b1) begin fails++; $display("FAIL areset_pre_inflight: got %b want 1", s2_v); end
    Req_i = 1'b0; Ack_i = 1'b0; Valid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    tests++; if (Valid_o !== 1'b0) begin fails++; $display("FAIL areset_valid: got %b want 0", Valid_o); end
    tests++; if (Gnt_o !== 1'b1) begin fails++; $display("FAIL areset_gnt: got %b want 1", Gnt_o); end
    tests++; if (Overflow_o !== 1'b0) begin fails++; $display("FAIL areset_ovf: got %b want 0", Overflow_o); end
    tests++; if ({Res_o, Tag_o, Status_o} !== 45'h0) begin fails++; $display("FAIL areset_data: got %h/%h/%h want 0", Res_o, Tag_o, Status_o); end
    clear_models();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    tests++; if (dut.rsv_q !== 3'd0) begin fails++; $display("FAIL areset_rsv: got %0d want 0", dut.rsv_q); end
    tests++; if (dut.occ_q !== 3'd0) begin fails++; $display("FAIL areset_occ: got %0d want 0", dut.occ_q); end
  endtask

  task automatic test_random();
    logic       req, ack;
    logic [7:0] id;
    int         errs;
    errs = 0;
    for (int n = 0; n < 10000; n++) begin
      req = ($urandom_range(0, 3) != 0);
      ack = ($urandom_range(0, 2) != 0);
      cycle(req, ack, 1'b0, 8'h00);
      tests++;
      if (Gnt_o !== (m_rsv < DEPTH) || Valid_o !== (m_occ != 0) || Overflow_o !== 1'b0 || dut.rsv_q > 3'd4) begin
        fails++; errs++;
        $display("FAIL rand_ctrl[%0d]: got gnt=%b vld=%b ovf=%b rsv=%0d want gnt=%b vld=%b ovf=0 rsv<=4",
                 n, Gnt_o, Valid_o, Overflow_o, dut.rsv_q, (m_rsv < DEPTH), (m_occ != 0));
      end
      if (m_occ != 0) begin
        id = exp_q[0];
        tests++;
        if (Tag_o !== id[4:0] || Res_o !== res_of(id) || Status_o !== status_of(id)) begin
          fails++; errs++;
          $display("FAIL rand_head[%0d]: got %h/%h/%h want %h/%h/%h", n, Tag_o, Res_o, Status_o, id[4:0], res_of(id), status_of(id));
        end
      end
      if (errs > 20) break;
    end
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 8'h00);
    tests++; if (Valid_o !== 1'b0 || exp_q.size() != 0) begin fails++; $display("FAIL rand_drain: got vld=%b left=%0d want 0/0", Valid_o, exp_q.size()); end
    tests++; if (dut.rsv_q !== 3'd0) begin fails++; $display("FAIL rand_rsv_end: got %0d want 0", dut.rsv_q); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_credit_full();
    test_full_wrap();
    test_overflow();
    test_async_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
